ir_beacon_tx: RTL and testbench

//  IR beacon transmitter: square wave on osig at a programmed frequency, for the rover's IR emitter LED.

---
 rtl/ir_beacon_tx_pkg.sv | 16 +
 rtl/ir_beacon_tx_if.sv | 14 +
 rtl/ir_beacon_tx_div.sv | 71 +++++++
 rtl/ir_beacon_tx.sv | 141 ++++++++++++++
 tb/tb_ir_beacon_tx.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ir_beacon_tx_pkg.sv
// ir_pkg: shared definitions for the IR beacon transmitter.
//   CLK_HZ_DEF  default clock frequency
//   gen_state_t generator state encoding
//   freq_valid  accepts 0 < freq <= clk_hz/2
package ir_pkg;

  localparam int unsigned CLK_HZ_DEF = 50_000_000;
  localparam int unsigned FREQ_LIMIT_DEF = CLK_HZ_DEF / 2;

  typedef enum logic [1:0] {G_IDLE, G_CONT, G_BURST} gen_state_t;

  function automatic logic freq_valid(input logic [63:0] freq, input logic [63:0] clk_hz);
    return (freq != '0) && (freq <= (clk_hz / 64'd2));
  endfunction

endpackage

// File: rtl/ir_beacon_tx_if.sv
// ir_beacon_tx_if: frequency configuration handshake.
//   freq_hz    requested frequency, sampled when cfg_valid && cfg_ready
//   cfg_valid  request from the master
//   cfg_ready  slave can accept (divider idle)
//   cfg_err    1-cycle pulse for a rejected request
interface ir_beacon_tx_if #(parameter int unsigned DIV_W = 32);
  logic [DIV_W-1:0] freq_hz;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output freq_hz, cfg_valid, input cfg_ready, cfg_err);
  modport slave  (input freq_hz, cfg_valid, output cfg_ready, cfg_err);
endinterface

// File: rtl/ir_beacon_tx_div.sv
// ir_div_seq: restoring divider, one quotient bit per cycle, W cycles per divide.
//   clk, reset  clock, synchronous active-high reset (aborts a divide)
//   start       begin a divide when not busy
//   dividend    W-bit numerator
//   divisor     W-bit denominator, must be >= 2
//   busy        divide in progress
//   done        1-cycle pulse when quotient is valid
//   quotient    W-1 bit result
import ir_pkg::*;

module ir_div_seq #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-2:0] quotient
);
  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  nq;
  logic [W-1:0]  d;
  logic [W-1:0]  r;
  logic [CW-1:0] cnt;
  logic [W:0]    rs;
  logic          ge;
  logic [W-1:0]  rn;

  // nq shifts the dividend out of its MSB while quotient bits enter at the LSB
  always_comb begin
    rs = {r, nq[W-1]};
    ge = (rs >= {1'b0, d});
    rn = ge ? (rs[W-1:0] - d) : rs[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      nq   <= '0;
      d    <= '0;
      r    <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        nq   <= dividend;
        d    <= divisor;
        r    <= '0;
        cnt  <= CW'(W);
      end else if (busy) begin
        r   <= rn;
        nq  <= {nq[W-2:0], ge};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // divisor >= 2, so the quotient MSB is always zero
  assign quotient = nq[W-2:0];

endmodule

// File: rtl/ir_beacon_tx.sv
// ir_beacon_tx: IR beacon square-wave generator with continuous and burst modes.
//   clk, reset   clock, synchronous active-high reset
//   cfg          configuration handshake (freq_hz, cfg_valid, cfg_ready, cfg_err)
//   run          level: continuous output enable
//   burst_start  pulse: emit burst_len full periods
//   burst_len    period count, sampled with burst_start
//   osig         beacon output
//   active       generator not idle
//   done         1-cycle pulse at burst end
import ir_pkg::*;

module ir_beacon_tx #(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
  parameter int unsigned DIV_W   = 32,
  parameter int unsigned BURST_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  ir_beacon_tx_if.slave      cfg,
  input  logic               run,
  input  logic               burst_start,
  input  logic [BURST_W-1:0] burst_len,
  output logic               osig,
  output logic               active,
  output logic               done
);
  localparam int unsigned QW = DIV_W + 1;
  localparam logic [QW-1:0] NUM = QW'(CLK_HZ);

  logic             div_busy;
  logic             div_done;
  logic [DIV_W-1:0] quo;
  logic             accept;
  logic             ok;

  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign ok            = freq_valid(64'(cfg.freq_hz), 64'(CLK_HZ));
  assign cfg.cfg_ready = !div_busy;

  ir_div_seq #(.W(QW)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && ok),
    .dividend (NUM),
    .divisor  ({cfg.freq_hz, 1'b0}),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quo)
  );

  always_ff @(posedge clk) begin
    if (reset) cfg.cfg_err <= 1'b0;
    else       cfg.cfg_err <= accept && !ok;
  end

  gen_state_t         state;
  logic [DIV_W-1:0]   half_q;
  logic [DIV_W-1:0]   half_pend;
  logic               pend_v;
  logic [DIV_W-1:0]   cnt;
  logic [BURST_W-1:0] bcnt;
  logic               stop_req;
  logic [DIV_W-1:0]   half_eff;

  // a pending value is applied in the same cycle it is used for a (re)load,
  // so a start or toggle never loads a stale half-period
  assign half_eff = pend_v ? half_pend : half_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= G_IDLE;
      half_q    <= '0;
      half_pend <= '0;
      pend_v    <= 1'b0;
      cnt       <= '0;
      bcnt      <= '0;
      stop_req  <= 1'b0;
      osig      <= 1'b0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        G_IDLE: begin
          osig     <= 1'b0;
          active   <= 1'b0;
          stop_req <= 1'b0;
          if (pend_v) begin
            half_q <= half_pend;
            pend_v <= 1'b0;
          end
          if (burst_start && half_eff != '0 && burst_len != '0) begin
            state  <= G_BURST;
            bcnt   <= burst_len;
            cnt    <= half_eff - DIV_W'(1);
            osig   <= 1'b1;
            active <= 1'b1;
          end else if (run && half_eff != '0) begin
            state  <= G_CONT;
            cnt    <= half_eff - DIV_W'(1);
            osig   <= 1'b1;
            active <= 1'b1;
          end
        end
        G_CONT, G_BURST: begin
          if (state == G_CONT && !run) stop_req <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
          end else begin
            cnt  <= half_eff - DIV_W'(1);
            osig <= !osig;
            if (pend_v) begin
              half_q <= half_pend;
              pend_v <= 1'b0;
            end
            if (osig) begin
              if (state == G_CONT && (stop_req || !run)) begin
                state  <= G_IDLE;
                active <= 1'b0;
              end else if (state == G_BURST) begin
                bcnt <= bcnt - BURST_W'(1);
                if (bcnt == BURST_W'(1)) begin
                  state  <= G_IDLE;
                  active <= 1'b0;
                  done   <= 1'b1;
                end
              end
            end
          end
        end
        default: state <= G_IDLE;
      endcase
      // a fresh divider result overrides the clear from an apply this cycle
      if (div_done) begin
        half_pend <= quo;
        pend_v    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ir_beacon_tx.sv
module tb_ir_beacon_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        burst_start;
  logic [15:0] burst_len;
  logic        osig;
  logic        active;
  logic        done;

  int checks = 0;
  int errors = 0;

  ir_beacon_tx_if #(.DIV_W(32)) cfg_bus ();

  ir_beacon_tx #(.CLK_HZ(50_000_000), .DIV_W(32), .BURST_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg         (cfg_bus),
    .run         (run),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .osig        (osig),
    .active      (active),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_cfg(input logic [31:0] f);
    cfg_bus.freq_hz   = f;
    cfg_bus.cfg_valid = 1'b1;
    step(1);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cfg_bus.cfg_ready !== 1'b1 && n < 200) begin n++; step(1); end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_ready: cfg_ready still %b, required 1", cfg_bus.cfg_ready);
    end
  endtask

  task automatic wait_level(input logic lvl);
    int n = 0;
    while (osig !== lvl && n < 500) begin n++; step(1); end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL wait_level: osig %b, required %b", osig, lvl);
    end
  endtask

  task automatic get_phase(output logic lvl, output int len);
    lvl = osig;
    len = 0;
    while (osig === lvl && len < 2000) begin len++; step(1); end
    if (len >= 2000) begin
      checks++; errors++;
      $display("FAIL phase_timeout: osig stuck at %b", lvl);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; burst_start = 1'b0; burst_len = '0;
    cfg_bus.freq_hz = '0; cfg_bus.cfg_valid = 1'b0;
    step(3);
    checks++; if (osig !== 1'b0) begin errors++; $display("FAIL reset_osig: got %b required 0", osig); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b required 0", active); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (cfg_bus.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b required 0", cfg_bus.cfg_err); end
    checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b required 1", cfg_bus.cfg_ready); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_cont();
    int n = 0;
    logic lvl;
    int len;
    do_cfg(32'd1_000_000);
    while (cfg_bus.cfg_ready !== 1'b1 && n < 200) begin n++; step(1); end
    checks++; if (n != 33) begin errors++; $display("FAIL cfg_busy_cycles: got %0d required 33", n); end
    step(2);
    run = 1'b1;
    wait_level(1'b1);
    for (int k = 0; k < 4; k++) begin
      get_phase(lvl, len);
      checks++;
      if (len != 25 || lvl !== ((k % 2) == 0)) begin
        errors++; $display("FAIL cont_phase%0d: got lvl %b len %0d required lvl %b len 25", k, lvl, len, (k % 2) == 0);
      end
    end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL cont_active: got %b required 1", active); end
  endtask

  task automatic test_cfg_err();
    logic [31:0] bad [2];
    logic lvl;
    int len;
    bad[0] = 32'd0;
    bad[1] = 32'd30_000_000;
    for (int i = 0; i < 2; i++) begin
      do_cfg(bad[i]);
      checks++; if (cfg_bus.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse%0d: got %b required 1", i, cfg_bus.cfg_err); end
      step(1);
      checks++; if (cfg_bus.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear%0d: got %b required 0", i, cfg_bus.cfg_err); end
    end
    checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_err_ready: got %b required 1", cfg_bus.cfg_ready); end
    step(40);
    get_phase(lvl, len);
    for (int k = 0; k < 2; k++) begin
      get_phase(lvl, len);
      checks++; if (len != 25) begin errors++; $display("FAIL cfg_err_period%0d: got %0d required 25", k, len); end
    end
  endtask

  task automatic test_stop();
    int n = 0;
    int extra = 0;
    wait_level(1'b0);
    wait_level(1'b1);
    step(2);
    run = 1'b0;
    while (osig === 1'b1 && n < 100) begin n++; step(1); end
    checks++; if (2 + n != 25) begin errors++; $display("FAIL stop_high_len: got %0d required 25", 2 + n); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL stop_active: got %b required 0", active); end
    for (int i = 0; i < 100; i++) begin
      if (osig !== 1'b0 || active !== 1'b0) extra++;
      step(1);
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL stop_quiet: got %0d busy cycles required 0", extra); end
  endtask

  task automatic test_burst();
    logic lvl;
    int len;
    int extra = 0;
    do_cfg(32'd5_000_000);
    wait_ready();
    step(3);
    burst_start = 1'b1; burst_len = 16'd0;
    step(1);
    burst_start = 1'b0;
    step(2);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL burst_len0_active: got %b required 0", active); end
    burst_start = 1'b1; burst_len = 16'd3;
    step(1);
    burst_start = 1'b0;
    checks++; if (osig !== 1'b1) begin errors++; $display("FAIL burst_first_high: got %b required 1", osig); end
    for (int p = 0; p < 3; p++) begin
      get_phase(lvl, len);
      checks++; if (len != 5 || lvl !== 1'b1) begin errors++; $display("FAIL burst_high%0d: got lvl %b len %0d required lvl 1 len 5", p, lvl, len); end
      checks++; if (done !== (p == 2)) begin errors++; $display("FAIL burst_done%0d: got %b required %b", p, done, p == 2); end
      checks++; if (active !== (p != 2)) begin errors++; $display("FAIL burst_active%0d: got %b required %b", p, active, p != 2); end
      if (p < 2) begin
        get_phase(lvl, len);
        checks++; if (len != 5) begin errors++; $display("FAIL burst_low%0d: got %0d required 5", p, len); end
      end
    end
    step(1);
    for (int i = 0; i < 60; i++) begin
      if (done !== 1'b0 || osig !== 1'b0) extra++;
      step(1);
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL burst_after: got %0d stray cycles required 0", extra); end
  endtask

  task automatic test_retune();
    logic lvl;
    int len;
    logic seen10 = 1'b0;
    do_cfg(32'd1_000_000);
    wait_ready();
    step(2);
    run = 1'b1;
    wait_level(1'b1);
    get_phase(lvl, len);
    checks++; if (len != 25) begin errors++; $display("FAIL retune_pre: got %0d required 25", len); end
    do_cfg(32'd2_500_000);
    get_phase(lvl, len);
    for (int k = 0; k < 10; k++) begin
      get_phase(lvl, len);
      checks++;
      if (!(len == 25 && !seen10) && len != 10) begin
        errors++; $display("FAIL retune_phase%0d: got %0d required 25 (before switch) or 10", k, len);
      end
      if (len == 10) seen10 = 1'b1;
    end
    checks++; if (len != 10) begin errors++; $display("FAIL retune_final: got %0d required 10", len); end
  endtask

  task automatic test_reset_burst();
    int n = 0;
    int extra = 0;
    run = 1'b0;
    while (active !== 1'b0 && n < 100) begin n++; step(1); end
    burst_start = 1'b1; burst_len = 16'd5;
    step(1);
    burst_start = 1'b0;
    step(12);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL rb_running: got %b required 1", active); end
    do_cfg(32'd1_000_000);
    step(3);
    reset = 1'b1;
    step(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rb_done_in_reset: got %b required 0", done); end
    step(1);
    reset = 1'b0;
    checks++; if (osig !== 1'b0) begin errors++; $display("FAIL rb_osig: got %b required 0", osig); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rb_active: got %b required 0", active); end
    checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL rb_cfg_ready: got %b required 1", cfg_bus.cfg_ready); end
    run = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (done !== 1'b0 || active !== 1'b0 || osig !== 1'b0) extra++;
      step(1);
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL rb_quiet: got %0d stray cycles required 0", extra); end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cont();
    test_cfg_err();
    test_stop();
    test_burst();
    test_retune();
    test_reset_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
